data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Shares a small number of data-memory channels among the per-thread LSU requesters of one core. Each channel runs a small state machine: it grants a requesting thread round-robin, forwards the request to memory, and relays the response back. The block sits between the core's `data_mem_*` per-thread ports and the external data memory. Both sides use the same valid/ready level handshake that the core already uses.

## Interface
Parameters:
- `ADDR_BITS`, 8, data memory address width
- `DATA_BITS`, 8, data memory word width
- `NUM_CONSUMERS`, 4, per-thread requesters (`THREADS_PER_BLOCK`)
- `NUM_CHANNELS`, 1, memory channels; 1 ≤ `NUM_CHANNELS` ≤ `NUM_CONSUMERS`

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `consumer_read_valid` in `[NUM_CONSUMERS]`: read request per thread.
- `consumer_read_address` in `[NUM_CONSUMERS]×ADDR_BITS`
- `consumer_read_ready` out `[NUM_CONSUMERS]`: read data valid.
- `consumer_read_data` out `[NUM_CONSUMERS]×DATA_BITS`
- `consumer_write_valid` in `[NUM_CONSUMERS]`
- `consumer_write_address` in `[NUM_CONSUMERS]×ADDR_BITS`
- `consumer_write_data` in `[NUM_CONSUMERS]×DATA_BITS`
- `consumer_write_ready` out `[NUM_CONSUMERS]`: write complete.
- `mem_read_valid` out `[NUM_CHANNELS]`
- `mem_read_address` out `[NUM_CHANNELS]×ADDR_BITS`
- `mem_read_ready` in `[NUM_CHANNELS]`
- `mem_read_data` in `[NUM_CHANNELS]×DATA_BITS`
- `mem_write_valid` out `[NUM_CHANNELS]`
- `mem_write_address` out `[NUM_CHANNELS]×ADDR_BITS`
- `mem_write_data` out `[NUM_CHANNELS]×DATA_BITS`
- `mem_write_ready` in `[NUM_CHANNELS]`

## Operation
- Handshake: a requester holds valid and its address/data stable until it sees ready. It then drops valid. Ready stays high until valid is low.
- Per-channel states:
  - IDLE → READ_WAIT or WRITE_WAIT on grant.
  - READ_WAIT → READ_RELAY on `mem_read_ready`.
  - WRITE_WAIT → WRITE_RELAY on `mem_write_ready`.
  - Each RELAY state → IDLE once the granted consumer's corresponding valid is low.
- Grant:
  - Eligible consumers have read or write valid and are not claimed by another channel.
  - Search starts at `rr_ptr+1` and wraps modulo `NUM_CONSUMERS`.
  - On grant, `rr_ptr` takes the granted index.
  - Channels are resolved in index order in the same cycle. A consumer claimed by a lower channel is excluded for higher channels.
- A consumer with both read and write valid gets the read first; the write is granted in a later cycle.
- On grant, the channel registers `mem_*_valid`=1 and latches the address (and data, for writes).
- On a WAIT→RELAY transition:
  - `mem_*_valid` goes to 0.
  - `consumer_*_ready` goes to 1; for reads, `consumer_read_data` takes `mem_read_data`.
- On a RELAY→IDLE transition, `consumer_*_ready` goes to 0 and the claim is released.
- The consumer index is held in a `$clog2(NUM_CONSUMERS)`-bit register; `rr_ptr` has the same width and wraps.

## Timing
- Reset values:
  - All `mem_*_valid` and `consumer_*_ready` are 0.
  - All data/address outputs are 0.
  - All channels are IDLE, `rr_ptr` = `NUM_CONSUMERS-1`, and no claims are held.
- Reset is asynchronous and aborts in-flight transactions. Requesters must re-issue after reset.
- Consumer valid sampled at edge E0:
  - `mem_*_valid` is high after E0.
  - With a registered memory that answers one cycle later, the channel sees memory ready at E2.
  - `consumer_*_ready` is high after E2: 2-cycle request-to-ready latency.
  - If the requester drops valid after E3, ready falls after E4 and the channel is reusable at E5.
- Stale memory ready is never seen, because the channel spends at least one cycle in RELAY after dropping `mem_*_valid`.
- A channel's `mem_*_valid` is never high while it is in RELAY or IDLE.
- Read and write valid are never both high on the same channel.

## Structure
- Package `gpu_mem_pkg` holds:
  - the `chan_state_t` enum: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY;
  - shared width localparams.
- Sub-module `mem_arb_channel`: one per channel. It contains the FSM, the latched consumer index, and the memory-side registers.
- Top level `data_mem_arbiter`: round-robin pick, claim mask, and consumer-side ready/data muxing.

## Test plan
- Single read:
  - Stimulus: consumer 1 reads address 2 (memory holds 3).
  - Required: `mem_read_address`=2; `consumer_read_ready[1]` high 2 cycles after the request with data 3; it drops one cycle after valid drops.
- Single write:
  - Stimulus: consumer 3 writes 9 to address 5.
  - Required: memory[5]=9; `consumer_write_ready[3]` pulses per the handshake.
- Contention, 1 channel:
  - Stimulus: all 4 consumers read addresses 0–3 in the same cycle.
  - Required: served in order 0, 1, 2, 3 with data 1, 2, 3, 4; no overlapping `mem_read_valid`.
- Fairness:
  - Stimulus: consumer 0 re-requests immediately after being served while consumer 2 is pending.
  - Required: consumer 2 is granted before consumer 0.
- 2 channels, 4 simultaneous requests:
  - Required: channel 0 takes consumer 0 and channel 1 takes consumer 1 on the same edge; no consumer is granted twice.
- Reset and read/write priority:
  - Stimulus: assert reset during READ_WAIT.
  - Required: all outputs are 0 immediately.
  - Stimulus: after release, consumer 0 asserts read and write together.
  - Required: the read completes first, then the write.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// Shared types and helpers for the data-memory arbiter and its channel FSMs.
package gpu_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    READ_RELAY,
    WRITE_RELAY
  } chan_state_t;

  localparam int DEF_ADDR_BITS     = 8;
  localparam int DEF_DATA_BITS     = 8;
  localparam int DEF_NUM_CONSUMERS = 4;
  localparam int DEF_NUM_CHANNELS  = 1;

  // Consumer index width; a single requester still needs one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rr_wrap(input int base, input int step, input int n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/mem_arb_channel.sv
// One memory channel: accepts a grant, drives the memory request, relays the
// response to the granted consumer and waits for that consumer to drop valid.
module mem_arb_channel
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_BITS     = DEF_ADDR_BITS,
  parameter int DATA_BITS     = DEF_DATA_BITS,
  parameter int NUM_CONSUMERS = DEF_NUM_CONSUMERS,
  parameter int IDXW          = idx_bits(NUM_CONSUMERS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     grant,
  input  logic                     grant_read,
  input  logic [IDXW-1:0]          grant_idx,
  input  logic [ADDR_BITS-1:0]     grant_addr,
  input  logic [DATA_BITS-1:0]     grant_data,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
  input  logic                     mem_read_ready,
  input  logic [DATA_BITS-1:0]     mem_read_data,
  input  logic                     mem_write_ready,
  output chan_state_t              state,
  output logic [IDXW-1:0]          idx,
  output logic                     mem_read_valid,
  output logic [ADDR_BITS-1:0]     mem_read_address,
  output logic                     mem_write_valid,
  output logic [ADDR_BITS-1:0]     mem_write_address,
  output logic [DATA_BITS-1:0]     mem_write_data,
  output logic                     read_ready,
  output logic                     write_ready,
  output logic [DATA_BITS-1:0]     read_data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      idx               <= '0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      read_ready        <= 1'b0;
      write_ready       <= 1'b0;
      read_data         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            idx <= grant_idx;
            if (grant_read) begin
              state            <= READ_WAIT;
              mem_read_valid   <= 1'b1;
              mem_read_address <= grant_addr;
            end else begin
              state             <= WRITE_WAIT;
              mem_write_valid   <= 1'b1;
              mem_write_address <= grant_addr;
              mem_write_data    <= grant_data;
            end
          end
        end
        READ_WAIT: begin
          if (mem_read_ready) begin
            mem_read_valid <= 1'b0;
            read_ready     <= 1'b1;
            read_data      <= mem_read_data;
            state          <= READ_RELAY;
          end
        end
        WRITE_WAIT: begin
          if (mem_write_ready) begin
            mem_write_valid <= 1'b0;
            write_ready     <= 1'b1;
            state           <= WRITE_RELAY;
          end
        end
        // Holding here until the consumer drops valid also masks the memory's
        // lagging ready from the just-finished request.
        READ_RELAY: begin
          if (!consumer_read_valid[idx]) begin
            read_ready <= 1'b0;
            state      <= IDLE;
          end
        end
        WRITE_RELAY: begin
          if (!consumer_write_valid[idx]) begin
            write_ready <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares NUM_CHANNELS data-memory channels among per-thread LSU requesters
// with a round-robin pick, a claim mask and consumer-side response muxing.
module data_mem_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_BITS     = DEF_ADDR_BITS,
  parameter int DATA_BITS     = DEF_DATA_BITS,
  parameter int NUM_CONSUMERS = DEF_NUM_CONSUMERS,
  parameter int NUM_CHANNELS  = DEF_NUM_CHANNELS
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

  localparam int IDXW = idx_bits(NUM_CONSUMERS);

  chan_state_t [NUM_CHANNELS-1:0]                 ch_state;
  logic        [NUM_CHANNELS-1:0][IDXW-1:0]       ch_idx;
  logic        [NUM_CHANNELS-1:0]                 ch_rrdy;
  logic        [NUM_CHANNELS-1:0]                 ch_wrdy;
  logic        [NUM_CHANNELS-1:0][DATA_BITS-1:0]  ch_rdata;

  logic        [NUM_CHANNELS-1:0]                 gnt;
  logic        [NUM_CHANNELS-1:0]                 gnt_rd;
  logic        [NUM_CHANNELS-1:0][IDXW-1:0]       gnt_idx;
  logic        [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  gnt_addr;
  logic        [NUM_CHANNELS-1:0][DATA_BITS-1:0]  gnt_data;

  logic [IDXW-1:0]          rr_ptr, rr_next;
  logic [NUM_CONSUMERS-1:0] held, taken;
  logic [IDXW-1:0]          cand;
  logic                     found;

  // A consumer stays claimed from grant until its channel returns to IDLE.
  always_comb begin
    held = '0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (ch_state[c] != IDLE) held[ch_idx[c]] = 1'b1;
  end

  // Channels resolve in index order; each grant is masked from later channels.
  always_comb begin
    taken    = held;
    rr_next  = rr_ptr;
    gnt      = '0;
    gnt_rd   = '0;
    gnt_idx  = '0;
    gnt_addr = '0;
    gnt_data = '0;
    cand     = '0;
    found    = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      found = 1'b0;
      if (ch_state[c] == IDLE) begin
        for (int k = 1; k <= NUM_CONSUMERS; k++) begin
          cand = IDXW'(rr_wrap(int'(rr_ptr), k, NUM_CONSUMERS));
          if (!found && !taken[cand] &&
              (consumer_read_valid[cand] || consumer_write_valid[cand])) begin
            found      = 1'b1;
            gnt[c]     = 1'b1;
            gnt_idx[c] = cand;
            // Read wins when both are pending; the write is picked up later.
            gnt_rd[c]   = consumer_read_valid[cand];
            gnt_addr[c] = consumer_read_valid[cand] ? consumer_read_address[cand]
                                                    : consumer_write_address[cand];
            gnt_data[c] = consumer_write_data[cand];
          end
        end
        if (found) begin
          taken[gnt_idx[c]] = 1'b1;
          rr_next           = gnt_idx[c];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr <= IDXW'(NUM_CONSUMERS - 1);
    else       rr_ptr <= rr_next;
  end

  always_comb begin
    consumer_read_ready  = '0;
    consumer_write_ready = '0;
    consumer_read_data   = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (ch_rrdy[c]) begin
        consumer_read_ready[ch_idx[c]] = 1'b1;
        consumer_read_data[ch_idx[c]]  = ch_rdata[c];
      end
      if (ch_wrdy[c]) consumer_write_ready[ch_idx[c]] = 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    mem_arb_channel #(
      .ADDR_BITS     (ADDR_BITS),
      .DATA_BITS     (DATA_BITS),
      .NUM_CONSUMERS (NUM_CONSUMERS),
      .IDXW          (IDXW)
    ) u_chan (
      .clk                  (clk),
      .reset                (reset),
      .grant                (gnt[c]),
      .grant_read           (gnt_rd[c]),
      .grant_idx            (gnt_idx[c]),
      .grant_addr           (gnt_addr[c]),
      .grant_data           (gnt_data[c]),
      .consumer_read_valid  (consumer_read_valid),
      .consumer_write_valid (consumer_write_valid),
      .mem_read_ready       (mem_read_ready[c]),
      .mem_read_data        (mem_read_data[c]),
      .mem_write_ready      (mem_write_ready[c]),
      .state                (ch_state[c]),
      .idx                  (ch_idx[c]),
      .mem_read_valid       (mem_read_valid[c]),
      .mem_read_address     (mem_read_address[c]),
      .mem_write_valid      (mem_write_valid[c]),
      .mem_write_address    (mem_write_address[c]),
      .mem_write_data       (mem_write_data[c]),
      .read_ready           (ch_rrdy[c]),
      .write_ready          (ch_wrdy[c]),
      .read_data            (ch_rdata[c])
    );
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a 1-channel and a 2-channel instance, each with a
// registered memory model; table vectors, corner sequences and random traffic.
module tb_data_mem_arbiter;

  logic clk, reset;

  logic [3:0]       a_rv, a_wv, a_rrdy, a_wrdy;
  logic [3:0][7:0]  a_ra, a_wa, a_wd, a_rd;
  logic [0:0]       a_mrv, a_mwv, a_mrr, a_mwr;
  logic [0:0][7:0]  a_mra, a_mwa, a_mwd, a_mrd;

  logic [3:0]       b_rv, b_wv, b_rrdy, b_wrdy;
  logic [3:0][7:0]  b_ra, b_wa, b_wd, b_rd;
  logic [1:0]       b_mrv, b_mwv, b_mrr, b_mwr;
  logic [1:0][7:0]  b_mra, b_mwa, b_mwd, b_mrd;

  logic [7:0] ma [256];
  logic [7:0] mb [256];
  logic [7:0] rb [256];

  data_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) dut_a (
    .clk(clk), .reset(reset),
    .consumer_read_valid(a_rv), .consumer_read_address(a_ra),
    .consumer_read_ready(a_rrdy), .consumer_read_data(a_rd),
    .consumer_write_valid(a_wv), .consumer_write_address(a_wa),
    .consumer_write_data(a_wd), .consumer_write_ready(a_wrdy),
    .mem_read_valid(a_mrv), .mem_read_address(a_mra),
    .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
    .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
    .mem_write_data(a_mwd), .mem_write_ready(a_mwr));

  data_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) dut_b (
    .clk(clk), .reset(reset),
    .consumer_read_valid(b_rv), .consumer_read_address(b_ra),
    .consumer_read_ready(b_rrdy), .consumer_read_data(b_rd),
    .consumer_write_valid(b_wv), .consumer_write_address(b_wa),
    .consumer_write_data(b_wd), .consumer_write_ready(b_wrdy),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered memories: answer one cycle after seeing valid; word i holds i+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ma[i] <= 8'(i + 1);
      a_mrr <= '0; a_mwr <= '0; a_mrd <= '0;
    end else begin
      a_mrr[0] <= a_mrv[0];
      a_mwr[0] <= a_mwv[0];
      a_mrd[0] <= ma[a_mra[0]];
      if (a_mwv[0]) ma[a_mwa[0]] <= a_mwd[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mb[i] <= 8'(i + 1);
      b_mrr <= '0; b_mwr <= '0; b_mrd <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        b_mrr[c] <= b_mrv[c];
        b_mwr[c] <= b_mwv[c];
        b_mrd[c] <= mb[b_mra[c]];
        if (b_mwv[c]) mb[b_mwa[c]] <= b_mwd[c];
      end
    end
  end

  typedef struct { bit b; int cons; bit wr; logic [7:0] data; int cyc; } ev_t;
  typedef struct { int c; bit wr; logic [7:0] addr; logic [7:0] wd; logic [7:0] exp; } vec_t;

  ev_t  evq[$];
  vec_t tv[8];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, rises = 0, rand_cnt = 0;
  bit   prev_mrv = 1'b0, rand_on = 1'b0;
  int   left[4];
  int   iss[4];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // One clock: sample after the edge, run consumer agents (drop valid on ready),
  // score random traffic against the reference memory, then issue new requests.
  task automatic cycle();
    logic [7:0] ad;
    @(posedge clk); #1; cyc++;
    if (a_mrv[0] && !prev_mrv) rises++;
    prev_mrv = a_mrv[0];
    if (a_rrdy != '0 || a_wrdy != '0)
      chk("mem_valid_during_relay", 32'({a_mrv, a_mwv}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (a_rv[i] && a_rrdy[i]) begin
        evq.push_back('{1'b0, i, 1'b0, a_rd[i], cyc}); a_rv[i] = 1'b0;
      end
      if (a_wv[i] && a_wrdy[i]) begin
        evq.push_back('{1'b0, i, 1'b1, 8'h00, cyc}); a_wv[i] = 1'b0;
      end
      if (b_rv[i] && b_rrdy[i]) begin
        evq.push_back('{1'b1, i, 1'b0, b_rd[i], cyc}); b_rv[i] = 1'b0;
        if (rand_on) begin
          chk("rand_read_data", 32'(b_rd[i]), 32'(rb[b_ra[i]]));
          chk("rand_latency_bound", 32'(cyc - iss[i] <= 40), 32'd1);
          rand_cnt++;
        end
      end
      if (b_wv[i] && b_wrdy[i]) begin
        evq.push_back('{1'b1, i, 1'b1, 8'h00, cyc}); b_wv[i] = 1'b0;
        if (rand_on) begin
          rb[b_wa[i]] = b_wd[i];
          chk("rand_write_mem", 32'(mb[b_wa[i]]), 32'(b_wd[i]));
          chk("rand_latency_bound", 32'(cyc - iss[i] <= 40), 32'd1);
          rand_cnt++;
        end
      end
    end
    if (rand_on)
      for (int i = 0; i < 4; i++)
        if (!b_rv[i] && !b_wv[i] && !b_rrdy[i] && !b_wrdy[i] && left[i] > 0 &&
            $urandom_range(0, 1) == 1) begin
          left[i]--;
          iss[i] = cyc;
          ad = 8'(i * 64 + int'($urandom_range(0, 63)));
          if ($urandom_range(0, 1) == 1) begin
            b_wv[i] = 1'b1; b_wa[i] = ad; b_wd[i] = 8'($urandom);
          end else begin
            b_rv[i] = 1'b1; b_ra[i] = ad;
          end
        end
  endtask

  task automatic wait_log(input int n, input int bound);
    int k = 0;
    while (evq.size() < n && k < bound) begin cycle(); k++; end
    chk("completion_count", 32'(evq.size()), 32'(n));
  endtask

  initial begin
    int cnt[4];
    int c0;
    vec_t v;
    tv[0] = '{1, 1'b0, 8'h02, 8'h00, 8'h03};
    tv[1] = '{3, 1'b1, 8'h05, 8'h09, 8'h09};
    tv[2] = '{3, 1'b0, 8'h05, 8'h00, 8'h09};
    tv[3] = '{0, 1'b0, 8'hFF, 8'h00, 8'h00};
    tv[4] = '{2, 1'b1, 8'h40, 8'hAA, 8'hAA};
    tv[5] = '{1, 1'b0, 8'h40, 8'h00, 8'hAA};
    tv[6] = '{0, 1'b1, 8'hFF, 8'hFF, 8'hFF};
    tv[7] = '{2, 1'b0, 8'hFF, 8'h00, 8'hFF};

    a_rv = '0; a_wv = '0; a_ra = '0; a_wa = '0; a_wd = '0;
    b_rv = '0; b_wv = '0; b_ra = '0; b_wa = '0; b_wd = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a_mem_valid", 32'({a_mrv, a_mwv}), 32'd0);
    chk("reset_a_mem_addr", 32'({a_mra, a_mwa, a_mwd}), 32'd0);
    chk("reset_a_ready", 32'({a_rrdy, a_wrdy}), 32'd0);
    chk("reset_a_rdata", 32'(a_rd), 32'd0);
    chk("reset_b_mem_valid", 32'({b_mrv, b_mwv}), 32'd0);
    chk("reset_b_ready_data", 32'({b_rrdy, b_wrdy, b_rd[0], b_rd[1]}), 32'd0);
    for (int i = 0; i < 256; i++) rb[i] = 8'(i + 1);
    reset = 1'b0;
    cycle();

    // Contention on one channel from the reset pointer: order 0,1,2,3.
    evq.delete(); rises = 0;
    for (int i = 0; i < 4; i++) begin a_rv[i] = 1'b1; a_ra[i] = 8'(i); end
    wait_log(4, 80);
    for (int k = 0; k < 4 && k < evq.size(); k++) begin
      chk("contention_order", 32'(evq[k].cons), 32'(k));
      chk("contention_data", 32'(evq[k].data), 32'(k + 1));
    end
    repeat (3) cycle();
    chk("contention_mem_valid_pulses", 32'(rises), 32'd4);

    // Table vectors: single transactions on the 1-channel instance.
    for (int k = 0; k < 8; k++) begin
      v = tv[k];
      evq.delete();
      c0 = cyc;
      if (v.wr) begin a_wv[v.c] = 1'b1; a_wa[v.c] = v.addr; a_wd[v.c] = v.wd; end
      else      begin a_rv[v.c] = 1'b1; a_ra[v.c] = v.addr; end
      cycle();
      if (v.wr) begin
        chk("vec_mem_write_valid", 32'(a_mwv[0]), 32'd1);
        chk("vec_mem_write_addr", 32'(a_mwa[0]), 32'(v.addr));
        chk("vec_mem_write_data", 32'(a_mwd[0]), 32'(v.wd));
      end else begin
        chk("vec_mem_read_valid", 32'(a_mrv[0]), 32'd1);
        chk("vec_mem_read_addr", 32'(a_mra[0]), 32'(v.addr));
      end
      wait_log(1, 20);
      if (evq.size() > 0) begin
        chk("vec_latency", 32'(evq[0].cyc - (c0 + 1)), 32'd2);
        chk("vec_consumer", 32'(evq[0].cons), 32'(v.c));
        if (v.wr) chk("vec_mem_content", 32'(ma[v.addr]), 32'(v.exp));
        else      chk("vec_read_data", 32'(evq[0].data), 32'(v.exp));
      end
      cycle();
      chk("vec_ready_drop", 32'(v.wr ? a_wrdy[v.c] : a_rrdy[v.c]), 32'd0);
      cycle();
    end

    // Fairness: consumer 0 re-requests right after service while 2 waits.
    evq.delete();
    a_rv[0] = 1'b1; a_ra[0] = 8'h20;
    cycle();
    a_rv[2] = 1'b1; a_ra[2] = 8'h21;
    wait_log(1, 20);
    cycle();
    a_rv[0] = 1'b1; a_ra[0] = 8'h22;
    wait_log(3, 40);
    if (evq.size() >= 3) begin
      chk("fair_first", 32'(evq[0].cons), 32'd0);
      chk("fair_second", 32'(evq[1].cons), 32'd2);
      chk("fair_second_data", 32'(evq[1].data), 32'h22);
      chk("fair_third", 32'(evq[2].cons), 32'd0);
      chk("fair_third_data", 32'(evq[2].data), 32'h23);
    end
    repeat (3) cycle();

    // Two channels, four simultaneous reads.
    evq.delete();
    for (int i = 0; i < 4; i++) begin b_rv[i] = 1'b1; b_ra[i] = 8'(i); cnt[i] = 0; end
    cycle();
    chk("two_ch_both_valid", 32'(b_mrv), 32'd3);
    chk("two_ch_addr0", 32'(b_mra[0]), 32'd0);
    chk("two_ch_addr1", 32'(b_mra[1]), 32'd1);
    wait_log(4, 60);
    foreach (evq[k]) begin
      cnt[evq[k].cons]++;
      chk("two_ch_data", 32'(evq[k].data), 32'(evq[k].cons + 1));
    end
    for (int i = 0; i < 4; i++) chk("two_ch_served_once", 32'(cnt[i]), 32'd1);
    repeat (3) cycle();

    // Random traffic on the 2-channel instance against the reference memory.
    for (int i = 0; i < 4; i++) left[i] = 12;
    rand_cnt = 0;
    rand_on = 1'b1;
    begin
      int k = 0;
      while (k < 3000 && !((left[0] + left[1] + left[2] + left[3]) == 0 &&
                           b_rv == '0 && b_wv == '0)) begin
        cycle(); k++;
      end
    end
    rand_on = 1'b0;
    chk("rand_txn_count", 32'(rand_cnt), 32'd48);
    repeat (3) cycle();

    // Reset in READ_WAIT, then simultaneous read+write from consumer 0.
    evq.delete();
    a_rv[1] = 1'b1; a_ra[1] = 8'h07;
    cycle();
    #2;
    reset = 1'b1; a_rv = '0;
    #1;
    chk("midreset_mem_valid", 32'({a_mrv, a_mwv}), 32'd0);
    chk("midreset_mem_addr", 32'({a_mra, a_mwa, a_mwd}), 32'd0);
    chk("midreset_ready", 32'({a_rrdy, a_wrdy}), 32'd0);
    chk("midreset_rdata", 32'(a_rd), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    a_rv[0] = 1'b1; a_ra[0] = 8'h0A;
    a_wv[0] = 1'b1; a_wa[0] = 8'h0B; a_wd[0] = 8'h55;
    wait_log(2, 40);
    if (evq.size() >= 2) begin
      chk("prio_read_first", 32'(evq[0].wr), 32'd0);
      chk("prio_read_data", 32'(evq[0].data), 32'h0B);
      chk("prio_write_second", 32'(evq[1].wr), 32'd1);
    end
    chk("prio_write_mem", 32'(ma[8'h0B]), 32'h55);
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
